// File: rtl/riscv_rf_mp.sv
// RV12 multi-port integer register file.
// Provides prioritised write ports, optional write-to-read bypass, clear-after-reset and debug access.

// One registered read operand. Performs the range check and the optional bypass from writes committing on the same edge.
module riscv_rf_mp_rd #(
  parameter int XLEN    = 32,
  parameter int AR_BITS = 5,
  parameter int NREGS   = 32,
  parameter int NW      = 2,
  parameter int BYPASS  = 1
)(
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        en,
  input  logic [AR_BITS-1:0]          addr,
  input  logic [XLEN-1:0]             mem_q,
  input  logic [NW-1:0][AR_BITS-1:0]  w_addr,
  input  logic [NW-1:0][XLEN-1:0]     w_data,
  input  logic [NW-1:0]               w_en,
  output logic [XLEN-1:0]             q
);
  logic [XLEN-1:0] nxt;

  // w_en is ordered by priority, so the last match is the value that commits
  always_comb begin
    nxt = '0;
    if (en && addr != '0 && int'(addr) < NREGS) begin
      nxt = mem_q;
      if (BYPASS != 0)
        for (int i = 0; i < NW; i++)
          if (w_en[i] && w_addr[i] == addr) nxt = w_data[i];
    end
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) q <= '0;
    else       q <= nxt;
endmodule

module riscv_rf_mp #(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int AR_BITS    = 5,
  parameter int RDPORTS    = 2,
  parameter int WRPORTS    = 1,
  parameter int BYPASS     = 1,
  parameter int CLR_ON_RST = 1
)(
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [RDPORTS-1:0][AR_BITS-1:0]   rf_src1,
  input  logic [RDPORTS-1:0][AR_BITS-1:0]   rf_src2,
  output logic [RDPORTS-1:0][XLEN-1:0]      rf_srcv1,
  output logic [RDPORTS-1:0][XLEN-1:0]      rf_srcv2,
  input  logic [WRPORTS-1:0][AR_BITS-1:0]   rf_dst,
  input  logic [WRPORTS-1:0][XLEN-1:0]      rf_dstv,
  input  logic [WRPORTS-1:0]                rf_we,
  output logic                              rf_ready,
  output logic                              rf_wr_err,
  input  logic                              du_stall,
  input  logic                              du_req,
  input  logic                              du_we,
  input  logic [AR_BITS-1:0]                du_addr,
  input  logic [XLEN-1:0]                   du_dato,
  output logic [XLEN-1:0]                   du_dati,
  output logic                              du_ack
);
  localparam int NW = WRPORTS + 1;
  localparam int RI = $clog2(NREGS);

  typedef enum logic {INIT, READY} state_t;
  state_t state, state_nxt;

  logic [AR_BITS-1:0]          clr_cnt;
  logic [XLEN-1:0]             mem [NREGS];
  logic                        ready, du_acc, du_wr;
  logic [NW-1:0][AR_BITS-1:0]  w_addr;
  logic [NW-1:0][XLEN-1:0]     w_data;
  logic [NW-1:0]               w_req, w_en, w_oor;

  function automatic logic in_rng(input logic [AR_BITS-1:0] a);
    return int'(a) < NREGS;
  endfunction

  assign ready    = (state == READY);
  assign rf_ready = ready;
  // du_ack gates acceptance so a held request is serviced every other cycle
  assign du_acc   = ready & du_stall & du_req & ~du_ack;
  assign du_wr    = du_acc & du_we;

  // Debug write occupies the top slot so it overrides every port
  always_comb begin
    w_addr = '0;
    w_data = '0;
    w_req  = '0;
    w_en   = '0;
    w_oor  = '0;
    for (int i = 0; i < WRPORTS; i++) begin
      w_addr[i] = rf_dst[i];
      w_data[i] = rf_dstv[i];
      w_req[i]  = ready & rf_we[i];
    end
    w_addr[WRPORTS] = du_addr;
    w_data[WRPORTS] = du_dato;
    w_req[WRPORTS]  = du_wr;
    for (int i = 0; i < NW; i++) begin
      w_oor[i] = w_req[i] & ~in_rng(w_addr[i]);
      w_en[i]  = w_req[i] & in_rng(w_addr[i]) & (w_addr[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= INIT;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (CLR_ON_RST == 0 || int'(clr_cnt) == NREGS - 1) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn)              clr_cnt <= AR_BITS'(1);
    else if (state == INIT) clr_cnt <= clr_cnt + 1'b1;

  // Array is deliberately unreset; the INIT sweep provides the zeroing
  always_ff @(posedge clk) begin
    if (state == INIT && CLR_ON_RST != 0) mem[clr_cnt[RI-1:0]] <= '0;
    for (int i = 0; i < NW; i++)
      if (w_en[i]) mem[w_addr[i][RI-1:0]] <= w_data[i];
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      du_ack    <= 1'b0;
      du_dati   <= '0;
      rf_wr_err <= 1'b0;
    end else begin
      du_ack    <= du_acc;
      rf_wr_err <= |w_oor;
      if (du_acc && !du_we)
        du_dati <= (du_addr != '0 && in_rng(du_addr)) ? mem[du_addr[RI-1:0]] : '0;
    end

  for (genvar g = 0; g < RDPORTS; g++) begin : g_rd
    logic [XLEN-1:0] m1, m2;
    assign m1 = mem[rf_src1[g][RI-1:0]];
    assign m2 = mem[rf_src2[g][RI-1:0]];

    riscv_rf_mp_rd #(.XLEN(XLEN), .AR_BITS(AR_BITS), .NREGS(NREGS), .NW(NW), .BYPASS(BYPASS))
      u_rd1 (.clk(clk), .rstn(rstn), .en(ready), .addr(rf_src1[g]), .mem_q(m1),
             .w_addr(w_addr), .w_data(w_data), .w_en(w_en), .q(rf_srcv1[g]));

    riscv_rf_mp_rd #(.XLEN(XLEN), .AR_BITS(AR_BITS), .NREGS(NREGS), .NW(NW), .BYPASS(BYPASS))
      u_rd2 (.clk(clk), .rstn(rstn), .en(ready), .addr(rf_src2[g]), .mem_q(m2),
             .w_addr(w_addr), .w_data(w_data), .w_en(w_en), .q(rf_srcv2[g]));
  end
endmodule

// File: tb/tb_riscv_rf_mp.sv
// Bench for riscv_rf_mp. Instance u_a: 32 entries, 2 write ports, bypass enabled.
// Instance u_b: 16 entries, 1 write port, no bypass; it shares port 0 with u_a.
module tb_riscv_rf_mp;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [1:0][4:0]  src1, src2, dst;
  logic [1:0][31:0] dstv;
  logic [1:0]       we;
  logic             du_stall, du_req, du_we;
  logic [4:0]       du_addr;
  logic [31:0]      du_dato;

  logic [1:0][31:0] srcv1_a, srcv2_a;
  logic             rdy_a, err_a, ack_a;
  logic [31:0]      dati_a;

  logic [0:0][4:0]  b_src1, b_src2, b_dst;
  logic [0:0][31:0] b_dstv, srcv1_b, srcv2_b;
  logic             rdy_b, err_b, ack_b;
  logic [31:0]      dati_b;
  assign b_src1[0] = src1[0];
  assign b_src2[0] = src2[0];
  assign b_dst[0]  = dst[0];
  assign b_dstv[0] = dstv[0];

  riscv_rf_mp #(.WRPORTS(2)) u_a (
    .clk(clk), .rstn(rstn), .rf_src1(src1), .rf_src2(src2), .rf_srcv1(srcv1_a), .rf_srcv2(srcv2_a),
    .rf_dst(dst), .rf_dstv(dstv), .rf_we(we), .rf_ready(rdy_a), .rf_wr_err(err_a),
    .du_stall(du_stall), .du_req(du_req), .du_we(du_we), .du_addr(du_addr), .du_dato(du_dato),
    .du_dati(dati_a), .du_ack(ack_a));

  riscv_rf_mp #(.NREGS(16), .RDPORTS(1), .WRPORTS(1), .BYPASS(0)) u_b (
    .clk(clk), .rstn(rstn), .rf_src1(b_src1), .rf_src2(b_src2), .rf_srcv1(srcv1_b), .rf_srcv2(srcv2_b),
    .rf_dst(b_dst), .rf_dstv(b_dstv), .rf_we(we[0:0]), .rf_ready(rdy_b), .rf_wr_err(err_b),
    .du_stall(1'b0), .du_req(1'b0), .du_we(1'b0), .du_addr(5'd0), .du_dato(32'd0),
    .du_dati(dati_b), .du_ack(ack_b));

  typedef struct {
    logic [3:0][31:0] av;
    logic [1:0][31:0] bv;
    logic             errb;
    logic             ack;
    logic [31:0]      dati;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ma[32];
  logic [31:0] mb[16];
  logic        exp_ack;
  logic [31:0] exp_dati;
  int          n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_a(input logic [4:0] a, input logic acc);
    logic [31:0] r;
    if (a == 5'd0) return 32'd0;
    r = ma[a];
    if (we[0] && dst[0] == a) r = dstv[0];
    if (we[1] && dst[1] == a) r = dstv[1];
    if (acc && du_we && du_addr == a) r = du_dato;
    return r;
  endfunction

  function automatic logic [31:0] rd_b(input logic [4:0] a);
    if (a == 5'd0 || a >= 5'd16) return 32'd0;
    return mb[a[3:0]];
  endfunction

  task automatic idle();
    we = 2'b00; dst = '0; dstv = '0; src1 = '0; src2 = '0;
    du_stall = 1'b0; du_req = 1'b0; du_we = 1'b0; du_addr = '0; du_dato = '0;
  endtask

  // Predict one cycle from the current inputs, update the model, then compare after the edge
  task automatic step();
    exp_t e;
    logic acc;
    acc = du_stall && du_req && !exp_ack;
    e.av[0] = rd_a(src1[0], acc);
    e.av[1] = rd_a(src2[0], acc);
    e.av[2] = rd_a(src1[1], acc);
    e.av[3] = rd_a(src2[1], acc);
    e.bv[0] = rd_b(src1[0]);
    e.bv[1] = rd_b(src2[0]);
    e.errb  = we[0] && dst[0] >= 5'd16;
    if (acc && !du_we) exp_dati = (du_addr == 5'd0) ? 32'd0 : ma[du_addr];
    exp_ack = acc;
    e.ack   = acc;
    e.dati  = exp_dati;
    sb.push_back(e);
    for (int i = 0; i < 2; i++) if (we[i] && dst[i] != 5'd0) ma[dst[i]] = dstv[i];
    if (acc && du_we && du_addr != 5'd0) ma[du_addr] = du_dato;
    if (we[0] && dst[0] != 5'd0 && dst[0] < 5'd16) mb[dst[0][3:0]] = dstv[0];
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("a_s1_0", srcv1_a[0], e.av[0]);
    chk("a_s2_0", srcv2_a[0], e.av[1]);
    chk("a_s1_1", srcv1_a[1], e.av[2]);
    chk("a_s2_1", srcv2_a[1], e.av[3]);
    chk("b_s1", srcv1_b[0], e.bv[0]);
    chk("b_s2", srcv2_b[0], e.bv[1]);
    chk("a_err", 32'(err_a), 32'd0);
    chk("b_err", 32'(err_b), 32'(e.errb));
    chk("du_ack", 32'(ack_a), 32'(e.ack));
    chk("du_dati", dati_a, e.dati);
  endtask

  initial begin
    int na, nb;
    idle();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(rdy_a), 32'd0);
    chk("rst_srcv", srcv1_a[0] | srcv2_a[1] | srcv1_b[0], 32'd0);
    chk("rst_ack", 32'(ack_a), 32'd0);
    chk("rst_err", 32'(err_a | err_b), 32'd0);
    chk("rst_dati", dati_a, 32'd0);

    // Port and debug traffic during the clear must be ignored
    src1[0] = 5'd3; we = 2'b10; dst[1] = 5'd3; dstv[1] = 32'h77;
    du_stall = 1'b1; du_req = 1'b1; du_we = 1'b1; du_addr = 5'd3; du_dato = 32'h99;
    @(negedge clk) rstn = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    chk("init_rdy", 32'(rdy_a), 32'd0);
    chk("init_rd", srcv1_a[0], 32'd0);
    chk("init_ack", 32'(ack_a), 32'd0);

    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_rdy", 32'(rdy_a | rdy_b), 32'd0);
    chk("mid_rst_srcv", srcv1_a[0], 32'd0);
    @(negedge clk) rstn = 1'b1;
    na = 0; nb = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (rdy_b && nb == 0) nb = n;
      if (n == 20) begin
        chk("init_rd2", srcv1_a[0], 32'd0);
        chk("init_ack2", 32'(ack_a), 32'd0);
      end
      if (rdy_a) begin na = n; break; end
    end
    chk("clr_cycles_a", 32'(na), 32'd31);
    chk("clr_cycles_b", 32'(nb), 32'd15);
    idle();

    for (int i = 0; i < 32; i++) ma[i] = 32'd0;
    for (int i = 0; i < 16; i++) mb[i] = 32'd0;
    exp_ack = 1'b0; exp_dati = 32'd0;

    // Every entry reads zero after the clear
    for (int i = 0; i < 8; i++) begin
      src1[0] = 5'(4*i); src2[0] = 5'(4*i+1); src1[1] = 5'(4*i+2); src2[1] = 5'(4*i+3);
      step();
    end

    // Same-address writes: port 1 wins
    idle(); we = 2'b11; dst[0] = 5'd5; dst[1] = 5'd5; dstv[0] = 32'hA; dstv[1] = 32'hB; src1[0] = 5'd5;
    step();
    idle(); src1[0] = 5'd5; step();

    // Bypass on u_a, old data on u_b
    idle(); we = 2'b01; dst[0] = 5'd7; dstv[0] = 32'h55; step();
    idle(); we = 2'b01; dst[0] = 5'd7; dstv[0] = 32'h1234; src1[0] = 5'd7; step();
    idle(); src1[0] = 5'd7; step();

    // Out-of-range write on the 16-entry instance
    idle(); we = 2'b01; dst[0] = 5'd4; dstv[0] = 32'h44; step();
    idle(); we = 2'b01; dst[0] = 5'd20; dstv[0] = 32'hFF; src1[0] = 5'd20; src2[0] = 5'd4; step();
    idle(); src1[0] = 5'd20; src2[0] = 5'd4; step();

    // Debug write beats port write; then debug read, held request, no stall
    idle(); du_stall = 1'b1; du_req = 1'b1; du_we = 1'b1; du_addr = 5'd9; du_dato = 32'hDEAD;
    we = 2'b01; dst[0] = 5'd9; dstv[0] = 32'h1; src1[0] = 5'd9; step();
    idle(); du_stall = 1'b1; src1[0] = 5'd9; step();
    du_req = 1'b1; du_we = 1'b0; du_addr = 5'd9;
    repeat (4) step();
    du_stall = 1'b0;
    repeat (2) step();

    for (int k = 0; k < 150; k++) begin
      src1 = {5'($urandom), 5'($urandom)};
      src2 = {5'($urandom), 5'($urandom)};
      dst  = {5'($urandom), 5'($urandom)};
      if ($urandom_range(0, 2) == 0) dst[1] = dst[0];
      if ($urandom_range(0, 2) == 0) src1[0] = dst[0];
      dstv = {$urandom, $urandom};
      we = 2'($urandom);
      du_stall = ($urandom_range(0, 3) != 0);
      du_req = $urandom_range(0, 1) == 1;
      du_we = $urandom_range(0, 1) == 1;
      du_addr = ($urandom_range(0, 1) == 1) ? dst[0] : 5'($urandom);
      du_dato = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
